pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 ADDR_W, 32, PC and target width in bits; legal range ADDR_W >= 3.
REQ-002 RESET_VEC, 32'h00000000 (ADDR_W bits), PC value loaded while fetch is disabled.
REQ-003 STALL_W, 6, stall vector width; bit 0 is the fetch stage.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (rst==0 resets at the clock edge).
REQ-006 stall  input  STALL_W  pipeline stall vector; only stall[0] consumed, other bits ignored.
REQ-007 flush  input  1  exception/eret redirect request, sampled each edge.
REQ-008 new_pc  input  ADDR_W  flush target address.
REQ-009 branch_flag  input  1  taken-branch redirect request from decode.
REQ-010 branch_target  input  ADDR_W  branch target address.
REQ-011 pc  output  ADDR_W  current fetch address, registered.
REQ-012 ce  output  1  instruction-memory chip enable, registered.
REQ-013 redirect_pending  output  1  a deferred branch target is held, registered.
REQ-014 misalign  output  1  registered; 1 when pc[1:0] != 0.

Function
REQ-015 ce SHALL load 0 on any edge with rst==0, else 1; ce rises on the first edge with rst==1.
REQ-016 On any edge with rst==0 or ce==0, pc SHALL load RESET_VEC, pending SHALL clear and misalign SHALL clear.
REQ-017 With ce==1, next-PC selection priority SHALL be: flush > branch_flag > pending target > sequential > hold.
REQ-018 flush==1: pc <= new_pc regardless of stall[0]; pending cleared; same-cycle branch_flag discarded.
REQ-019 branch_flag==1, stall[0]==0: pc <= branch_target; pending cleared.
REQ-020 branch_flag==1, stall[0]==1: pc held; branch_target stored in pending register; redirect_pending <= 1; a newer deferred branch overwrites an older one.
REQ-021 pending==1, no flush/branch, stall[0]==0: pc <= stored target; redirect_pending <= 0.
REQ-022 No flush/branch/pending, stall[0]==0: pc <= pc + 4, modulo 2^ADDR_W (wraps to 0, no flag).
REQ-023 stall[0]==1 with no flush: pc SHALL hold its value.
REQ-024 misalign SHALL be updated on every pc load to (loaded value[1:0] != 0) and held otherwise; pc is never auto-aligned.
REQ-025 States: DISABLED (ce=0), RUN (ce=1, pending=0), HELD (ce=1, pending=1).
REQ-026 DISABLED->RUN on edge with rst==1; RUN->HELD on branch during stall[0]; HELD->RUN on stall[0] release or flush; any state->DISABLED on rst==0.
REQ-027 Latency: every redirect is visible on pc one edge after the accepting edge; a deferred branch is visible one edge after stall[0] deasserts.

Reset
REQ-028 Reset values: ce=0, pc=RESET_VEC, redirect_pending=0, misalign=0, stored target don't-care.
REQ-029 One reset edge SHALL fully initialise the block; rst==0 mid-operation (including in HELD) SHALL discard the pending target.
REQ-030 First edge after reset release: ce=1, pc remains RESET_VEC; sequential fetch begins on the following edge.

Verification
REQ-031 rst=0 for 2 edges then 1, stall=0 -> ce 0,0,1,1...; pc 0,0,0,4,8 (RESET_VEC=0).
REQ-032 branch_target=0xFFFFFFFC, branch_flag pulse, stall=0 -> pc=0xFFFFFFFC, then next edge pc=0x00000000.
REQ-033 pc=0x40, stall[0]=1, branch_flag pulse target 0x100, stall held 2 more edges -> pc=0x40, redirect_pending=1; release -> pc=0x100, pending=0; next pc=0x104.
REQ-034 HELD with target 0x100, stall[0]=1, flush with new_pc=0x180 and branch_flag target 0x200 same edge -> pc=0x180, redirect_pending=0.
REQ-035 branch_target=0x102 -> misalign=1; next edge pc=0x106, misalign=1; then branch to 0x200 -> misalign=0.
REQ-036 HELD with target 0x300, rst=0 one edge, then rst=1, stall=0 -> pc=RESET_VEC, redirect_pending=0; 0x300 never appears on pc.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bus between pipeline control and the PC unit
interface pc_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pending;
  logic               misalign;
  modport master (
    output stall, flush, new_pc, branch_flag, branch_target,
    input  pc, ce, redirect_pending, misalign
  );
  modport slave (
    input  stall, flush, new_pc, branch_flag, branch_target,
    output pc, ce, redirect_pending, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with flush/branch redirect and stall-deferred branch target
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STALL_W   = 6
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  typedef enum logic [1:0] {DISABLED, RUN, HELD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic              mis_q, mis_d;
  logic              stall_f;
  assign stall_f = bus.stall[0];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    if (state_q == DISABLED) begin
      state_d = RUN;
      pc_d    = RESET_VEC;
    end else if (bus.flush) begin
      state_d = RUN;
      pc_d    = bus.new_pc;
    end else if (bus.branch_flag) begin
      state_d = stall_f ? HELD : RUN;
      pc_d    = stall_f ? pc_q : bus.branch_target;
      tgt_d   = stall_f ? bus.branch_target : tgt_q;
    end else if (!stall_f) begin
      state_d = RUN;
      pc_d    = (state_q == HELD) ? tgt_q : pc_q + ADDR_W'(4);
    end
    mis_d = (state_q == DISABLED) ? 1'b0 : (pc_d[1:0] != 2'b00);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DISABLED;
      pc_q    <= RESET_VEC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
    tgt_q <= tgt_d;
  end
  assign bus.pc               = pc_q;
  assign bus.ce               = state_q != DISABLED;
  assign bus.redirect_pending = state_q == HELD;
  assign bus.misalign         = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pc_unit_if #(.ADDR_W(32), .STALL_W(6)) bus ();
  pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .STALL_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_step = 0;
  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
    end
  endtask
  int mon_idx = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      mon_idx++;
      check("pc", mon_idx, bus.pc, e.pc);
      check("ce", mon_idx, {31'b0, bus.ce}, {31'b0, e.ce});
      check("redirect_pending", mon_idx, {31'b0, bus.redirect_pending}, {31'b0, e.pend});
      check("misalign", mon_idx, {31'b0, bus.misalign}, {31'b0, e.mis});
    end
  end
  task automatic step(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt,
                      input logic [31:0] epc, input logic ece, input logic ep, input logic em);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.new_pc        = np;
    bus.branch_flag   = b;
    bus.branch_target = bt;
    e.pc = epc; e.ce = ece; e.pend = ep; e.mis = em;
    exp_q.push_back(e);
    n_step++;
  endtask
  initial begin
    bus.stall = '0; bus.flush = 0; bus.new_pc = '0; bus.branch_flag = 0; bus.branch_target = '0;
    // reset for two edges, then sequential fetch starts one edge after release
    step(0, 6'd0, 0, 0, 0, 0,            32'h0, 0, 0, 0);
    step(0, 6'd0, 0, 0, 0, 0,            32'h0, 0, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h0, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h4, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h8, 1, 0, 0);
    // branch to top of address space, then wrap
    step(1, 6'd0, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h0, 1, 0, 0);
    step(1, 6'd0, 0, 0, 1, 32'h40,       32'h40, 1, 0, 0);
    // branch deferred by stall, released later
    step(1, 6'd1, 0, 0, 1, 32'h100,      32'h40, 1, 1, 0);
    step(1, 6'd1, 0, 0, 0, 0,            32'h40, 1, 1, 0);
    step(1, 6'd1, 0, 0, 0, 0,            32'h40, 1, 1, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h100, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h104, 1, 0, 0);
    // flush beats pending and a same-cycle branch, even under stall
    step(1, 6'd1, 0, 0, 1, 32'h100,      32'h104, 1, 1, 0);
    step(1, 6'd1, 1, 32'h180, 1, 32'h200, 32'h180, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h184, 1, 0, 0);
    // plain stall holds; upper stall bits ignored
    step(1, 6'd1, 0, 0, 0, 0,            32'h184, 1, 0, 0);
    step(1, 6'b111110, 0, 0, 0, 0,       32'h188, 1, 0, 0);
    // misaligned target propagates through sequential fetch
    step(1, 6'd0, 0, 0, 1, 32'h102,      32'h102, 1, 0, 1);
    step(1, 6'd0, 0, 0, 0, 0,            32'h106, 1, 0, 1);
    step(1, 6'd0, 0, 0, 1, 32'h200,      32'h200, 1, 0, 0);
    // newer deferred branch overwrites older one
    step(1, 6'd1, 0, 0, 1, 32'h400,      32'h200, 1, 1, 0);
    step(1, 6'd1, 0, 0, 1, 32'h500,      32'h200, 1, 1, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h500, 1, 0, 0);
    // flush under stall with nothing pending
    step(1, 6'd1, 1, 32'h1000, 0, 0,     32'h1000, 1, 0, 0);
    // reset while HELD discards the pending target
    step(1, 6'd1, 0, 0, 1, 32'h300,      32'h1000, 1, 1, 0);
    step(0, 6'd1, 0, 0, 0, 0,            32'h0, 0, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h0, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h4, 1, 0, 0);
    step(1, 6'd0, 0, 0, 0, 0,            32'h8, 1, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0 || mon_idx != n_step) begin
      n_fail++;
      $display("FAIL drain: %0d responses checked, expected %0d", mon_idx, n_step);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
